tile_hit_judge: RTL and testbench

Judges player key presses against the tiles in the judge row and produces the score `increment` stream and miss/life bookkeeping for the game. It sits between the lane buttons and tile generator on one side and the score register on the other. The score register counts one point per two `increment`-high clock cycles, so this block emits exactly two consecutive high cycles per judged hit.

---
 rtl/tile_hit_judge_if.sv | 25 ++
 rtl/tile_hit_judge.sv | 104 ++++++++++
 tb/tb_tile_hit_judge.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tile_hit_judge_if.sv
// Lane/game-side bus of the tile hit judge: game controls, lane buttons,
// judge-row tile flags in; score strobe and miss/life bookkeeping out.
interface tile_hit_judge_if #(
  parameter int LANES = 4
);
  logic             startn;
  logic [5:0]       current_state;
  logic [LANES-1:0] keyn;
  logic [LANES-1:0] zone;
  logic             zone_exit;
  logic             increment;
  logic             miss;
  logic [1:0]       lives;
  logic             game_over;

  modport master (
    output startn, current_state, keyn, zone, zone_exit,
    input  increment, miss, lives, game_over
  );

  modport slave (
    input  startn, current_state, keyn, zone, zone_exit,
    output increment, miss, lives, game_over
  );
endinterface

// File: rtl/tile_hit_judge.sv
// Tile hit judge: synchronises lane buttons, judges presses against the
// judge row, queues hits and emits two increment-high cycles per hit.
module tile_hit_judge #(
  parameter int         LANES      = 4,
  parameter logic [5:0] PLAY_STATE = 6'd2,
  parameter int         LIVES      = 3
) (
  input logic              clock,
  input logic              resetn,
  tile_hit_judge_if.slave  bus
);
  // Wide enough for pending + a full chord without overflow before saturating.
  localparam int CW = $clog2(LANES + 1) + 3;

  typedef enum logic [1:0] {P_IDLE, P_HI1, P_HI2} pulse_e;

  pulse_e           r_state, w_state_nxt;
  logic [LANES-1:0] r_k1, r_k2, r_k3;
  logic [LANES-1:0] r_hit_done;
  logic [2:0]       r_pending;
  logic [1:0]       r_lives;
  logic             r_game_over;
  logic             r_miss;

  logic             w_clr, w_active, w_miss_ev, w_dec;
  logic [LANES-1:0] w_press, w_open, w_hit, w_wrong, w_missed;
  logic [CW-1:0]    w_nhits, w_pend_sum;
  logic [2:0]       w_pend_nxt;

  assign w_clr    = !resetn | (!bus.startn & (bus.current_state == 6'd0));
  assign w_press  = r_k3 & ~r_k2;
  assign w_active = (bus.current_state == PLAY_STATE) & !r_game_over;
  assign w_open   = bus.zone & ~r_hit_done;
  assign w_hit    = w_active ? (w_press & w_open) : '0;
  assign w_wrong  = w_active ? (w_press & ~w_open) : '0;
  // A lane hit in the exit cycle is credited, so it cannot also miss.
  assign w_missed = (w_active & bus.zone_exit) ? (w_open & ~w_press) : '0;
  assign w_miss_ev = (|w_wrong) | (|w_missed);
  assign w_dec    = (r_state == P_HI2);

  // Count hits this cycle.
  always_comb begin
    w_nhits = '0;
    for (int i = 0; i < LANES; i++) w_nhits = w_nhits + CW'(w_hit[i]);
  end

  // Net pending update; w_dec only fires with pending >= 1, so no underflow.
  assign w_pend_sum = CW'(r_pending) + w_nhits - CW'(w_dec);
  assign w_pend_nxt = (w_pend_sum > CW'(7)) ? 3'd7 : w_pend_sum[2:0];

  // Pulse FSM next state: two high cycles then at least one low per hit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      P_IDLE:  if (r_pending != 3'd0) w_state_nxt = P_HI1;
      P_HI1:   w_state_nxt = P_HI2;
      P_HI2:   w_state_nxt = P_IDLE;
      default: w_state_nxt = P_IDLE;
    endcase
  end

  // Pulse FSM state register; a clear discards any pulse in flight.
  always_ff @(posedge clock) begin
    if (w_clr) r_state <= P_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Two-flop synchroniser plus edge flop; idle level is released (ones).
  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_k1 <= '1;
      r_k2 <= '1;
      r_k3 <= '1;
    end else begin
      r_k1 <= bus.keyn;
      r_k2 <= r_k1;
      r_k3 <= r_k2;
    end
  end

  // Judge bookkeeping: per-lane hit flags, hit queue, miss pulse and lives.
  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_hit_done  <= '0;
      r_pending   <= 3'd0;
      r_lives     <= 2'(LIVES);
      r_game_over <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      r_hit_done <= (w_active & bus.zone_exit) ? '0 : (r_hit_done | w_hit);
      r_pending  <= w_pend_nxt;
      r_miss     <= w_miss_ev;
      if (w_miss_ev && (r_lives != 2'd0)) begin
        r_lives <= r_lives - 2'd1;
        if (r_lives == 2'd1) r_game_over <= 1'b1;
      end
    end
  end

  assign bus.increment = (r_state != P_IDLE);
  assign bus.miss      = r_miss;
  assign bus.lives     = r_lives;
  assign bus.game_over = r_game_over;
endmodule

// File: tb/tb_tile_hit_judge.sv
// Bench for tile_hit_judge: a directed vector table, scenario sequences,
// and random stimulus, all checked each cycle against a credit/lives model.
module tb_tile_hit_judge;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  tile_hit_judge_if #(.LANES(4)) bus ();

  tile_hit_judge #(.LANES(4), .PLAY_STATE(6'd2), .LIVES(3)) dut (
    .clock(clock), .resetn(resetn), .bus(bus)
  );

  int nerr = 0;
  int nchk = 0;
  int n_inc = 0;
  int n_miss = 0;

  // Reference model: key sample history, unmatched-tile flags, queued
  // score credits, position within the current score pulse, lives.
  logic [3:0] m_hist[3];
  logic [3:0] m_done;
  int         m_pend, m_phase, m_lives;
  bit         m_go, m_miss;

  typedef struct {
    logic [3:0] keyn;
    logic [3:0] zone;
    logic       zx;
    logic       rstn;
    logic       inc;
    logic       miss;
    logic [1:0] lives;
    logic       go;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs present at the
  // edge, then compare DUT outputs against it 1ns later.
  task automatic step();
    logic [3:0] press, hitl;
    int nh, nphase;
    bit mev, clr, active;
    clr = !resetn || (!bus.startn && bus.current_state == 6'd0);
    if (clr) begin
      m_hist = '{4'hF, 4'hF, 4'hF};
      m_done = 4'h0; m_pend = 0; m_phase = 0;
      m_lives = 3; m_go = 0; m_miss = 0;
    end else begin
      press = m_hist[2] & ~m_hist[1];
      hitl = 4'h0; nh = 0; mev = 0;
      active = (bus.current_state == 6'd2) && !m_go;
      if (active) begin
        for (int i = 0; i < 4; i++)
          if (press[i]) begin
            if (bus.zone[i] && !m_done[i]) begin hitl[i] = 1'b1; nh++; end
            else mev = 1;
          end
        if (bus.zone_exit) begin
          for (int i = 0; i < 4; i++)
            if (bus.zone[i] && !m_done[i] && !hitl[i]) mev = 1;
          m_done = 4'h0;
        end else m_done = m_done | hitl;
      end
      if (m_phase == 0) nphase = (m_pend > 0) ? 1 : 0;
      else              nphase = (m_phase == 1) ? 2 : 0;
      m_pend = m_pend + nh - ((m_phase == 2) ? 1 : 0);
      if (m_pend > 7) m_pend = 7;
      m_phase = nphase;
      m_miss = mev;
      if (mev && m_lives > 0) begin
        m_lives--;
        if (m_lives == 0) m_go = 1;
      end
      m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = bus.keyn;
    end
    @(posedge clock);
    #1;
    chk("model_inc", int'(bus.increment), (m_phase != 0) ? 1 : 0);
    chk("model_miss", int'(bus.miss), int'(m_miss));
    chk("model_lives", int'(bus.lives), m_lives);
    chk("model_go", int'(bus.game_over), int'(m_go));
    n_inc += int'(bus.increment);
    n_miss += int'(bus.miss);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    resetn = 1'b0; bus.keyn = 4'hF; bus.zone_exit = 1'b0;
    step();
    resetn = 1'b1; bus.current_state = 6'd2; bus.startn = 1'b1;
    n_inc = 0; n_miss = 0;
  endtask

  logic [15:0] pat;

  initial begin
    resetn = 1'b0; bus.startn = 1'b1; bus.current_state = 6'd2;
    bus.keyn = 4'hF; bus.zone = 4'h0; bus.zone_exit = 1'b0;
    m_hist = '{4'hF, 4'hF, 4'hF};
    m_done = 4'h0; m_pend = 0; m_phase = 0; m_lives = 3; m_go = 0; m_miss = 0;

    // keyn, zone, zone_exit, resetn -> increment, miss, lives, game_over
    tbl[0]  = '{4'hF, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[1]  = '{4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[2]  = '{4'hE, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[3]  = '{4'hE, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[4]  = '{4'hE, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[5]  = '{4'hE, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[6]  = '{4'hE, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[7]  = '{4'hE, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[8]  = '{4'hE, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[9]  = '{4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[10] = '{4'hD, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[11] = '{4'hD, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[12] = '{4'hD, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
    tbl[13] = '{4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[14] = '{4'hF, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[15] = '{4'hF, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};

    // Single hit, wrong key, missed tile on exit.
    for (int r = 0; r < 16; r++) begin
      bus.keyn = tbl[r].keyn; bus.zone = tbl[r].zone;
      bus.zone_exit = tbl[r].zx; resetn = tbl[r].rstn;
      step();
      chk($sformatf("tbl%0d_inc", r), int'(bus.increment), int'(tbl[r].inc));
      chk($sformatf("tbl%0d_miss", r), int'(bus.miss), int'(tbl[r].miss));
      chk($sformatf("tbl%0d_lives", r), int'(bus.lives), int'(tbl[r].lives));
      chk($sformatf("tbl%0d_go", r), int'(bus.game_over), int'(tbl[r].go));
    end

    // Four-lane chord: four pulses of period 3, then a wrong-key re-press.
    do_clear();
    bus.zone = 4'hF; bus.keyn = 4'h0;
    pat = '0;
    for (int i = 0; i < 16; i++) begin step(); pat[i] = bus.increment; end
    chk("chord_pattern", int'(pat), int'(16'b0011011011011000));
    chk("chord_inc", n_inc, 8);
    chk("chord_miss", n_miss, 0);
    bus.keyn = 4'hF; steps(2);
    bus.keyn = 4'hE; steps(3);
    bus.keyn = 4'hF; steps(2);
    chk("repress_miss", n_miss, 1);
    chk("repress_lives", int'(bus.lives), 2);

    // Missed tile: one of two tiles hit, exit gives a single miss event.
    do_clear();
    bus.zone = 4'h6; bus.keyn = 4'hD; steps(3);
    bus.keyn = 4'hF; steps(2);
    bus.zone_exit = 1'b1; step();
    bus.zone_exit = 1'b0; steps(6);
    chk("mtile_miss", n_miss, 1);
    chk("mtile_lives", int'(bus.lives), 2);
    chk("mtile_inc", n_inc, 2);

    // Hit judged in the same cycle as zone_exit.
    do_clear();
    bus.zone = 4'h4; bus.keyn = 4'hB; step();
    step();
    bus.zone_exit = 1'b1; step();
    bus.zone_exit = 1'b0; bus.keyn = 4'hF; steps(6);
    chk("exit_hit_miss", n_miss, 0);
    chk("exit_hit_inc", n_inc, 2);
    chk("exit_hit_lives", int'(bus.lives), 3);

    // Game over after three miss events, then a new-game clear.
    do_clear();
    bus.zone = 4'h0;
    for (int j = 0; j < 3; j++) begin
      bus.keyn = 4'hE; steps(3);
      bus.keyn = 4'hF; steps(3);
    end
    chk("go_lives", int'(bus.lives), 0);
    chk("go_flag", int'(bus.game_over), 1);
    n_inc = 0; n_miss = 0;
    bus.zone = 4'hF; bus.keyn = 4'h0; steps(3);
    bus.keyn = 4'hF; steps(8);
    chk("go_no_inc", n_inc, 0);
    chk("go_no_miss", n_miss, 0);
    bus.startn = 1'b0; bus.current_state = 6'd0; step();
    bus.startn = 1'b1; bus.current_state = 6'd2;
    chk("newgame_lives", int'(bus.lives), 3);
    chk("newgame_go", int'(bus.game_over), 0);

    // Reset while the first of three queued pulses is high.
    do_clear();
    bus.zone = 4'hF; bus.keyn = 4'h8;
    for (int i = 0; i < 10 && !bus.increment; i++) step();
    chk("rst_reached_hi1", int'(bus.increment), 1);
    resetn = 1'b0; bus.keyn = 4'hF; step();
    chk("rst_inc_low", int'(bus.increment), 0);
    resetn = 1'b1; n_inc = 0;
    steps(12);
    chk("rst_no_pulses", n_inc, 0);

    // Random play against the model.
    do_clear();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) bus.keyn = 4'($urandom);
      bus.zone = 4'($urandom);
      bus.zone_exit = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0:       bus.current_state = 6'd0;
        1:       bus.current_state = 6'd1;
        default: bus.current_state = 6'd2;
      endcase
      bus.startn = ($urandom_range(0, 7) != 0);
      resetn = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
